median_window_feeder: RTL
=========================

// Module: median_window_feeder
// PURPOSE
//  Upstream stage of MEDIAN. Takes a raster pixel stream (valid/ready) and keeps two line buffers
//  plus a 3x3 window. For every pixel that completes a full 3x3 window, it emits a 9-cycle burst
//  (DSI_OUT high, window on DI_OUT) to MEDIAN. It then stalls the stream until MEDIAN pulses DSO.
// PARAMETERS
//  DATA_SIZE  8   pixel width in bits, must match MEDIAN DATA_SIZE
//  IMG_WIDTH  16  pixels per line, >=3; line buffer depth
//  COL_W      8   column counter width, 2**COL_W >= IMG_WIDTH
//  ROW_W      8   row counter width; row counter saturates at 2**ROW_W-1
// PORTS
//  CLK       in   1          clock, rising edge
//  nRST      in   1          asynchronous reset, active low
//  PIX_VALID in   1          input pixel valid
//  PIX_IN    in   DATA_SIZE  input pixel, raster order
//  SOF       in   1          start of frame; qualifies the pixel accepted in the same cycle
//  PIX_READY out  1          feeder can accept a pixel this cycle
//  DSI_OUT   out  1          to MEDIAN.DSI; high for exactly 9 consecutive cycles per window
//  DI_OUT    out  DATA_SIZE  to MEDIAN.DI; window pixel for the current burst cycle
//  MED_DSO   in   1          from MEDIAN.DSO; one-cycle pulse, median result valid
//  OUT_COL   out  COL_W      column of the window centre for the current/last burst
//  OUT_ROW   out  ROW_W      row of the window centre for the current/last burst
// BEHAVIOUR
//  Reset (nRST=0, async): state IDLE; PIX_READY=1 (combinational from IDLE); DSI_OUT=0; DI_OUT=0;
//   OUT_COL=0; OUT_ROW=0; col/row counters=0; burst index=0. Line buffers and window not reset.
//   Reset mid-burst aborts it; DSI_OUT drops asynchronously.
//  Accept: PIX_VALID & PIX_READY. If SOF is also high, the pixel is (col 0,row 0) and counters realign.
//   SOF without an accept is ignored.
//  On accept at column c, with W[r][k] where r=0 is the oldest row and k=2 is the newest column:
//   - W[r][0]<=W[r][1], W[r][1]<=W[r][2]
//   - W[0][2]<=LB1[c], W[1][2]<=LB0[c], W[2][2]<=PIX_IN
//   - LB1[c]<=LB0[c], LB0[c]<=PIX_IN
//   - col wraps IMG_WIDTH-1 -> 0 and increments row; row saturates
//  Window complete: accepted pixel has row>=2 and col>=2, using pre-increment coordinates.
//   Left-edge columns 0,1 never emit, so there is no wrap mixing across lines.
//  FSM:
//   IDLE: PIX_READY=1, DSI_OUT=0.
//    - Accept with complete window -> EMIT; latch OUT_COL=c-1, OUT_ROW=r-1; idx=0.
//    - Otherwise stay in IDLE.
//   EMIT: PIX_READY=0, DSI_OUT=1, DI_OUT=W[idx/3][idx%3], idx 0..8 in raster order
//    (W00,W01,W02,W10,...,W22). After idx=8 -> WAIT_MED.
//   WAIT_MED: PIX_READY=0, DSI_OUT=0, DI_OUT holds last value.
//    - MED_DSO=1 -> IDLE (PIX_READY=1 the next cycle).
//  Latency: accept at cycle T -> DSI_OUT=1 on cycles T+1..T+9; DSI_OUT=0 from T+10.
//  DSI_OUT, DI_OUT, OUT_COL and OUT_ROW are registered.
//  MED_DSO in IDLE or EMIT is ignored. The pixel stream is never dropped; backpressure only.
//  Throughput: one window per burst + MEDIAN processing time; non-emitting pixels take one cycle each.
// TESTING (IMG_WIDTH=4, pixel value = 10*row+col, MED_DSO model pulses 40 cycles after DSI falls)
//  1. Reset, then stream rows 0-1 (8 px) -> DSI_OUT stays 0, PIX_READY stays 1 throughout.
//  2. Accept px (row 2,col 2)=22 at T -> DSI_OUT=1 on T+1..T+9, DI_OUT=0,1,2,10,11,12,20,21,22;
//     OUT_COL=1, OUT_ROW=1.
//  3. PIX_VALID held high during a burst -> PIX_READY=0 from T+1 until the cycle after MED_DSO,
//     no pixel lost; next burst (col 3) DI_OUT=1,2,3,11,12,13,21,22,23.
//  4. Row wrap: px (3,0) and (3,1) -> no burst; px (3,2) -> DI_OUT=10,11,12,20,21,22,30,31,32.
//  5. SOF with pixel mid-frame -> counters realign; next 2 rows emit nothing; row 2 col 2 emits the
//     new frame data.
//  6. nRST low during EMIT (idx=4) -> DSI_OUT=0 immediately, PIX_READY=1; stray MED_DSO is ignored.

Source files
------------

// File: rtl/median_window_feeder.sv
// Line-buffered 3x3 window generator in front of MEDIAN: every pixel that completes a window
// triggers a 9-beat burst of the window, then the pixel stream stalls until MEDIAN answers.
module median_window_feeder #(
  parameter int DATA_SIZE = 8,
  parameter int IMG_WIDTH = 16,
  parameter int COL_W     = 8,
  parameter int ROW_W     = 8
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 PIX_VALID,
  input  logic [DATA_SIZE-1:0] PIX_IN,
  input  logic                 SOF,
  output logic                 PIX_READY,
  output logic                 DSI_OUT,
  output logic [DATA_SIZE-1:0] DI_OUT,
  input  logic                 MED_DSO,
  output logic [COL_W-1:0]     OUT_COL,
  output logic [ROW_W-1:0]     OUT_ROW
);

  localparam int ADDR_W = $clog2(IMG_WIDTH);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] EMIT     = 2'd1;
  localparam logic [1:0] WAIT_MED = 2'd2;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX  = '1;

  logic [1:0]           state_reg;
  logic [COL_W-1:0]     col_reg;
  logic [ROW_W-1:0]     row_reg;
  logic [3:0]           idx_reg;
  logic [3:0]           idx_inc;

  logic [DATA_SIZE-1:0] lb0 [IMG_WIDTH];
  logic [DATA_SIZE-1:0] lb1 [IMG_WIDTH];
  // Window flattened as index 3*r+k, r=0 oldest row, k=2 newest column.
  logic [DATA_SIZE-1:0] win_reg  [9];
  logic [DATA_SIZE-1:0] win_next [9];

  logic                 accept;
  logic                 complete;
  logic [COL_W-1:0]     cur_col;
  logic [COL_W-1:0]     col_next;
  logic [ROW_W-1:0]     cur_row;
  logic [ROW_W-1:0]     row_next;
  logic [ADDR_W-1:0]    lb_addr;
  logic [DATA_SIZE-1:0] lb0_rd;
  logic [DATA_SIZE-1:0] lb1_rd;

  assign PIX_READY = (state_reg == IDLE);
  assign accept    = PIX_VALID & PIX_READY;

  // SOF forces the accepted pixel to (0,0) regardless of where the counters were.
  assign cur_col  = SOF ? '0 : col_reg;
  assign cur_row  = SOF ? '0 : row_reg;
  assign complete = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));

  assign lb_addr = cur_col[ADDR_W-1:0];
  assign lb0_rd  = lb0[lb_addr];
  assign lb1_rd  = lb1[lb_addr];
  assign idx_inc = idx_reg + 4'd1;

  always_comb begin
    col_next = cur_col + COL_W'(1);
    row_next = cur_row;
    if (cur_col == COL_LAST) begin
      col_next = '0;
      if (cur_row != ROW_MAX) begin
        row_next = cur_row + ROW_W'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      win_next[3*i]   = win_reg[3*i+1];
      win_next[3*i+1] = win_reg[3*i+2];
      win_next[3*i+2] = win_reg[3*i+2];
    end
    win_next[2] = lb1_rd;
    win_next[5] = lb0_rd;
    win_next[8] = PIX_IN;
  end

  // Pixel storage is intentionally left without reset.
  always_ff @(posedge CLK) begin
    if (accept) begin
      lb1[lb_addr] <= lb0_rd;
      lb0[lb_addr] <= PIX_IN;
      for (int i = 0; i < 9; i++) begin
        win_reg[i] <= win_next[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
      col_reg   <= '0;
      row_reg   <= '0;
      idx_reg   <= '0;
      DSI_OUT   <= 1'b0;
      DI_OUT    <= '0;
      OUT_COL   <= '0;
      OUT_ROW   <= '0;
    end else begin
      if (accept) begin
        col_reg <= col_next;
        row_reg <= row_next;
      end
      case (state_reg)
        IDLE: begin
          if (accept && complete) begin
            state_reg <= EMIT;
            idx_reg   <= '0;
            DSI_OUT   <= 1'b1;
            DI_OUT    <= win_next[0];
            OUT_COL   <= cur_col - COL_W'(1);
            OUT_ROW   <= cur_row - ROW_W'(1);
          end
        end
        EMIT: begin
          if (idx_reg == 4'd8) begin
            state_reg <= WAIT_MED;
            DSI_OUT   <= 1'b0;
          end else begin
            idx_reg <= idx_inc;
            DI_OUT  <= win_reg[idx_inc];
          end
        end
        WAIT_MED: begin
          if (MED_DSO) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          DSI_OUT   <= 1'b0;
        end
      endcase
    end
  end

endmodule
